multiport_register_file: RTL and testbench

- Parametrised general-purpose register file for the pipeline: configurable data width, depth, read-port count and write-port count.
- Adds two things the single-port file lacks: a post-reset clearing sweep, and a per-register pending (scoreboard) bit for hazard detection.
- Sits between decode (reads, reservations) and writeback (writes); entry 0 is hardwired zero.

---
 rtl/multiport_register_file.sv | 94 +++++++++
 tb/tb_multiport_register_file.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Multiport register file with a post-reset clearing sweep and per-entry pending bits; REGISTER_FILE_BYPASS_EN adds same-cycle write-to-read bypass.
// Reads are combinational, writes/reservations land at posedge; no backpressure, but ready stays low for the DEPTH-cycle sweep.
module multiport_register_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    output logic                              ready,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_id,
    output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data,
    output logic [READ_PORTS-1:0]             read_pending,
    input  logic [WRITE_PORTS-1:0]            write_enable,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_id,
    input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data,
    input  logic                              reserve_enable,
    input  logic [ADDR_WIDTH-1:0]             reserve_id
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH:0]     counter;
    logic [DEPTH-1:0]        pending;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            counter <= '0;
            pending <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    for (int w = 0; w < WRITE_PORTS; w++) begin
                        if (write_enable[w] && write_id[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                            pending[write_id[w*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                    end
                    // A new reservation supersedes a same-cycle write to that register.
                    if (reserve_enable && reserve_id != '0)
                        pending[reserve_id] <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Ascending port order makes the highest-numbered write port win on conflicts.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[counter[ADDR_WIDTH-1:0]] <= '0;
        end else if (!reset) begin
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (write_enable[w] && write_id[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)
                    mem[write_id[w*ADDR_WIDTH +: ADDR_WIDTH]] <= write_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] rid;
        logic [DATA_WIDTH-1:0] rdat;

        assign rid = read_id[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rdat = mem[rid];
`ifdef REGISTER_FILE_BYPASS_EN
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (write_enable[w] && write_id[w*ADDR_WIDTH +: ADDR_WIDTH] != '0 &&
                    write_id[w*ADDR_WIDTH +: ADDR_WIDTH] == rid)
                    rdat = write_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
`endif
            if (!ready || rid == '0)
                rdat = '0;
        end

        assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = rdat;
        assign read_pending[p] = ready & pending[rid];
    end
endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised and directed bench for multiport_register_file (2 read, 2 write ports) against a behavioural model.
module tb_multiport_register_file;
    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [9:0]  read_id;
    logic [63:0] read_data;
    logic [1:0]  read_pending;
    logic [1:0]  write_enable;
    logic [9:0]  write_id;
    logic [63:0] write_data;
    logic        reserve_enable;
    logic [4:0]  reserve_id;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_ready;
    int          m_cnt;

    multiport_register_file #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_PORTS(2), .WRITE_PORTS(2)
    ) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .read_id(read_id), .read_data(read_data), .read_pending(read_pending),
        .write_enable(write_enable), .write_id(write_id), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_id(reserve_id)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_rd(input int p);
        logic [4:0]  id;
        logic [31:0] v;
        id = read_id[p*5 +: 5];
        if (!m_ready || id == 0) return 32'h0;
        v = m_mem[id];
`ifdef REGISTER_FILE_BYPASS_EN
        for (int w = 0; w < 2; w++)
            if (write_enable[w] && write_id[w*5 +: 5] != 0 && write_id[w*5 +: 5] == id)
                v = write_data[w*32 +: 32];
`endif
        return v;
    endfunction

    function automatic logic exp_pend(input int p);
        logic [4:0] id;
        id = read_id[p*5 +: 5];
        return m_ready && m_pend[id];
    endfunction

    task automatic model_reset();
        m_ready = 0;
        m_cnt   = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    task automatic model_update();
        if (reset) begin
            model_reset();
        end else if (!m_ready) begin
            m_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == 32) m_ready = 1;
        end else begin
            for (int w = 0; w < 2; w++)
                if (write_enable[w] && write_id[w*5 +: 5] != 0) begin
                    m_mem[write_id[w*5 +: 5]]  = write_data[w*32 +: 32];
                    m_pend[write_id[w*5 +: 5]] = 0;
                end
            if (reserve_enable && reserve_id != 0) m_pend[reserve_id] = 1;
        end
    endtask

    // Check reads against the model, clock once, then check ready.
    task automatic cycle();
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("read_data[%0d]", p), read_data[p*32 +: 32], exp_rd(p));
            check($sformatf("read_pending[%0d]", p), read_pending[p], exp_pend(p));
        end
        @(posedge clock);
        model_update();
        #1;
        check("ready", ready, m_ready);
    endtask

    task automatic idle();
        write_enable = 0; write_id = 0; write_data = 0;
        reserve_enable = 0; reserve_id = 0;
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 40 && ready !== 1'b1) begin
            cycle();
            lat++;
        end
    endtask

    initial begin
        int lat;
        idle();
        read_id = {5'd5, 5'd0};
        reset = 1;
        repeat (2) @(posedge clock);
        model_reset();
        #1;
        check("reset_ready", ready, 0);
        check("reset_read_data", read_data, 0);
        check("reset_read_pending", read_pending, 0);

        // Sweep timing and all-zero contents
        reset = 0;
        wait_ready(lat);
        check("sweep_latency", lat, 32);
        for (int i = 0; i < 16; i++) begin
            read_id = {5'(2*i + 1), 5'(2*i)};
            cycle();
        end

        // Mid-sweep reset with writes driven during the sweep
        reset = 1; cycle(); reset = 0;
        write_enable = 2'b01; write_id = {5'd0, 5'd3}; write_data = {32'h0, 32'hDEAD};
        repeat (10) cycle();
        reset = 1; cycle(); reset = 0;
        wait_ready(lat);
        check("mid_sweep_latency", lat, 32);
        idle();
        read_id = {5'd0, 5'd3};
        #1 check("mid_sweep_entry3", read_data[31:0], 0);
        cycle();

        // Write-port conflict and write to index 0
        write_enable = 2'b11; write_id = {5'd5, 5'd5}; write_data = {32'h22222222, 32'h11111111};
        cycle();
        write_enable = 2'b01; write_id = {5'd0, 5'd0}; write_data = {32'h0, 32'hFFFFFFFF};
        read_id = {5'd0, 5'd5};
        #1 check("conflict_high_port", read_data[31:0], 32'h22222222);
        cycle();
        idle();
        #1 check("zero_reg", read_data[63:32], 0);
        cycle();

        // Scoreboard, normal sequence
        reserve_enable = 1; reserve_id = 7;
        cycle();
        idle();
        read_id = {5'd0, 5'd7};
        #1 check("reserve_pending", read_pending[0], 1);
        write_enable = 2'b01; write_id = {5'd0, 5'd7}; write_data = {32'h0, 32'hABCD};
        cycle();
        idle();
        #1 check("write_clears_pending", read_pending[0], 0);
        check("write_data_7", read_data[31:0], 32'hABCD);
        cycle();

        // Simultaneous reserve and write
        reserve_enable = 1; reserve_id = 9;
        write_enable = 2'b10; write_id = {5'd9, 5'd0}; write_data = {32'h1234, 32'h0};
        cycle();
        idle();
        read_id = {5'd9, 5'd0};
        #1 check("reserve_wins_pending", read_pending[1], 1);
        check("reserve_write_data", read_data[63:32], 32'h1234);
        cycle();

        // Bypass behaviour
        write_enable = 2'b01; write_id = {5'd0, 5'd4}; write_data = {32'h0, 32'h1111};
        cycle();
        write_data = {32'h0, 32'hCAFE};
        read_id = {5'd0, 5'd4};
`ifdef REGISTER_FILE_BYPASS_EN
        #1 check("bypass_same_cycle", read_data[31:0], 32'hCAFE);
`else
        #1 check("no_bypass_same_cycle", read_data[31:0], 32'h1111);
`endif
        cycle();
        idle();
        #1 check("write_visible_next", read_data[31:0], 32'hCAFE);
        cycle();

        // Random traffic, small index range half the time to provoke conflicts
        for (int c = 0; c < 600; c++) begin
            logic [4:0] a0, a1, r0, r1;
            a0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r0 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r1 = ($urandom_range(0, 1) == 1) ? a1 : 5'($urandom);
            write_enable   = 2'($urandom);
            write_id       = {a1, a0};
            write_data     = {32'($urandom), 32'($urandom)};
            reserve_enable = 1'($urandom);
            reserve_id     = ($urandom_range(0, 1) == 1) ? a0 : 5'($urandom);
            read_id        = {r1, r0};
            reset          = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
